// File: rtl/cache_rd_arbiter_if.sv
// cache_rd_arbiter_if: read-side bundle between the two caches, the write-back tracker and the AXI3 AR/R channels.
// Ports (signals carried):
//   ic_rd_* / dc_rd_*   : cache read request (req, addr, len) and accept (rdy)
//   ic_ret_* / dc_ret_* : routed return beat (valid, last, data)
//   wb_busy / wb_addr   : pending write-back line/word, used for read hazard checks
//   ar* / r*            : AXI3 read address and read data channels
// Modports:
//   master : the arbiter (drives rdy/ret and the AXI master side)
//   slave  : the environment (caches, write-back tracker, AXI slave)
interface cache_rd_arbiter_if;
    logic        ic_rd_req;
    logic [31:0] ic_rd_addr;
    logic        ic_rd_len;
    logic        ic_rd_rdy;
    logic        ic_ret_valid;
    logic        ic_ret_last;
    logic [31:0] ic_ret_data;
    logic        dc_rd_req;
    logic [31:0] dc_rd_addr;
    logic        dc_rd_len;
    logic        dc_rd_rdy;
    logic        dc_ret_valid;
    logic        dc_ret_last;
    logic [31:0] dc_ret_data;
    logic        wb_busy;
    logic [31:0] wb_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  ic_rd_req, ic_rd_addr, ic_rd_len,
        output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        input  dc_rd_req, dc_rd_addr, dc_rd_len,
        output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        input  wb_busy, wb_addr,
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    modport slave (
        output ic_rd_req, ic_rd_addr, ic_rd_len,
        input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
        output dc_rd_req, dc_rd_addr, dc_rd_len,
        input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
        output wb_busy, wb_addr,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: arbitrates icache/dcache reads onto one AXI3 read port, tags by ARID, routes R beats by RID.
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset
//   bus    : cache_rd_arbiter_if.master (cache requests/returns, write-back hazard inputs, AXI AR/R)
// Parameters:
//   ID_IC / ID_DC : ARID values used for instruction / data cache reads
module cache_rd_arbiter #(
    parameter logic [3:0] ID_IC = 4'd0,
    parameter logic [3:0] ID_DC = 4'd1
) (
    input  logic               clk,
    input  logic               resetn,
    cache_rd_arbiter_if.master bus
);
    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

    ar_state_t   state, state_nxt;
    logic        os_ic, os_dc, os_ic_nxt, os_dc_nxt;
    logic        hz_ic, hz_dc;
    logic        elig_ic, elig_dc;
    logic        acc_ic, acc_dc, acc;
    logic        r_fire, last_ic, last_dc;
    logic        ret_ic, ret_dc;
    logic        sel_len;
    logic [31:0] sel_addr;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic        rready_q;

    // A read is held off while the write side still owns the same 16-byte line.
    assign hz_ic = bus.wb_busy & (bus.wb_addr[31:4] == bus.ic_rd_addr[31:4]);
    assign hz_dc = bus.wb_busy & (bus.wb_addr[31:4] == bus.dc_rd_addr[31:4]);

    // Gated by resetn so no request is acknowledged while reset is asserted.
    assign elig_ic = resetn & (state == AR_IDLE) & ~os_ic & bus.ic_rd_req & ~hz_ic;
    assign elig_dc = resetn & (state == AR_IDLE) & ~os_dc & bus.dc_rd_req & ~hz_dc;

    // Fixed priority: the data cache wins a simultaneous request.
    assign acc_dc = elig_dc;
    assign acc_ic = elig_ic & ~elig_dc;
    assign acc    = acc_ic | acc_dc;

    assign bus.dc_rd_rdy = acc_dc;
    assign bus.ic_rd_rdy = acc_ic;

    assign sel_addr = acc_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
    assign sel_len  = acc_dc ? bus.dc_rd_len  : bus.ic_rd_len;

    assign bus.arvalid = (state == AR_BUSY);
    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arsize  = arsize_q;
    assign bus.rready  = rready_q;

    // Beats with an unknown ID or for a requester with nothing outstanding are consumed and dropped.
    assign r_fire  = bus.rvalid & rready_q;
    assign last_ic = r_fire & bus.rlast & (bus.rid == ID_IC);
    assign last_dc = r_fire & bus.rlast & (bus.rid == ID_DC);
    assign ret_ic  = r_fire & (bus.rid == ID_IC) & os_ic;
    assign ret_dc  = r_fire & (bus.rid == ID_DC) & os_dc;

    assign bus.ic_ret_valid = ret_ic;
    assign bus.ic_ret_last  = ret_ic & bus.rlast;
    assign bus.ic_ret_data  = bus.rdata;
    assign bus.dc_ret_valid = ret_dc;
    assign bus.dc_ret_last  = ret_dc & bus.rlast;
    assign bus.dc_ret_data  = bus.rdata;

    always_comb begin
        state_nxt = state;
        os_ic_nxt = os_ic;
        os_dc_nxt = os_dc;
        if (state == AR_IDLE) begin
            state_nxt = acc ? AR_BUSY : AR_IDLE;
        end else begin
            state_nxt = bus.arready ? AR_IDLE : AR_BUSY;
        end
        // Accept and final beat cannot coincide for one requester since os blocks the accept.
        os_ic_nxt = acc_ic | (os_ic & ~last_ic);
        os_dc_nxt = acc_dc | (os_dc & ~last_dc);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= AR_IDLE;
            os_ic    <= 1'b0;
            os_dc    <= 1'b0;
            rready_q <= 1'b0;
            arid_q   <= 4'd0;
            araddr_q <= 32'd0;
            arlen_q  <= 8'd0;
            arsize_q <= 3'd0;
        end else begin
            state    <= state_nxt;
            os_ic    <= os_ic_nxt;
            os_dc    <= os_dc_nxt;
            rready_q <= 1'b1;
            if (acc) begin
                arid_q   <= acc_dc ? ID_DC : ID_IC;
                araddr_q <= sel_len ? {sel_addr[31:4], 4'b0} : sel_addr;
                arlen_q  <= sel_len ? 8'd3 : 8'd0;
                arsize_q <= 3'b010;
            end
        end
    end
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb_cache_rd_arbiter: scoreboard bench for cache_rd_arbiter using directed vectors.
module tb_cache_rd_arbiter;
    localparam logic [3:0] ID_IC = 4'd0;
    localparam logic [3:0] ID_DC = 4'd1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cache_rd_arbiter_if bus();

    cache_rd_arbiter #(.ID_IC(ID_IC), .ID_DC(ID_DC)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [46:0] ar_q[$];
    logic [32:0] ic_q[$];
    logic [32:0] dc_q[$];
    logic [46:0] ar_now;
    logic        hold_q = 1'b0;
    logic [46:0] hold_ar = '0;

    assign ar_now = {bus.arid, bus.araddr, bus.arlen, bus.arsize};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
        ar_q.push_back({id, a, l, 3'b010});
    endtask

    task automatic rbeat(input logic [3:0] id, input logic [31:0] d, input logic last, input logic want);
        bus.rvalid = 1'b1;
        bus.rid    = id;
        bus.rdata  = d;
        bus.rlast  = last;
        if (want) begin
            if (id == ID_IC) ic_q.push_back({last, d});
            else dc_q.push_back({last, d});
        end
    endtask

    task automatic r_off();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("rdy_exclusive", {bus.ic_rd_rdy, bus.dc_rd_rdy}, 2'b00 | {bus.ic_rd_rdy & ~bus.dc_rd_rdy, bus.dc_rd_rdy & ~bus.ic_rd_rdy});
        if (hold_q) chk("ar_stable", {bus.arvalid, ar_now}, {1'b1, hold_ar});
        if (bus.arvalid & bus.arready) begin
            if (ar_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ar_unexpected got=%0h exp=none", ar_now);
            end else chk("ar_txn", ar_now, ar_q.pop_front());
        end
        if (bus.ic_ret_valid) begin
            if (ic_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ic_ret_unexpected got=%0h exp=none", {bus.ic_ret_last, bus.ic_ret_data});
            end else chk("ic_ret", {bus.ic_ret_last, bus.ic_ret_data}, ic_q.pop_front());
        end
        if (bus.dc_ret_valid) begin
            if (dc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dc_ret_unexpected got=%0h exp=none", {bus.dc_ret_last, bus.dc_ret_data});
            end else chk("dc_ret", {bus.dc_ret_last, bus.dc_ret_data}, dc_q.pop_front());
        end
        hold_q  <= resetn & bus.arvalid & ~bus.arready;
        hold_ar <= ar_now;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        bus.ic_rd_req = 1'b0; bus.ic_rd_addr = '0; bus.ic_rd_len = 1'b0;
        bus.dc_rd_req = 1'b0; bus.dc_rd_addr = '0; bus.dc_rd_len = 1'b0;
        bus.wb_busy = 1'b0; bus.wb_addr = '0;
        bus.arready = 1'b0;
        bus.rid = '0; bus.rdata = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        cyc(3);
        // reset state
        bus.ic_rd_req = 1'b1;
        #1;
        chk("rst_rready", bus.rready, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_arid", bus.arid, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_arlen", bus.arlen, 0);
        chk("rst_arsize", bus.arsize, 0);
        chk("rst_ic_rdy", bus.ic_rd_rdy, 0);
        chk("rst_dc_rdy", bus.dc_rd_rdy, 0);
        chk("rst_ic_ret", bus.ic_ret_valid, 0);
        chk("rst_dc_ret", bus.dc_ret_valid, 0);
        bus.ic_rd_req = 1'b0;
        resetn = 1'b1;
        #1;
        chk("rready_pre", bus.rready, 0);
        cyc(1);
        chk("rready_post", bus.rready, 1);

        // single icache read
        bus.arready = 1'b1;
        bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1C00_0104; bus.ic_rd_len = 1'b0;
        #1;
        chk("t1_ic_rdy", bus.ic_rd_rdy, 1);
        chk("t1_dc_rdy", bus.dc_rd_rdy, 0);
        exp_ar(ID_IC, 32'h1C00_0104, 8'd0);
        cyc(1);
        bus.ic_rd_req = 1'b0;
        #1;
        chk("t1_arvalid", bus.arvalid, 1);
        chk("t1_araddr", bus.araddr, 32'h1C00_0104);
        chk("t1_arlen", bus.arlen, 0);
        cyc(1);
        rbeat(ID_IC, 32'hDEAD_BEEF, 1'b1, 1'b1);
        #1;
        chk("t1_ret_valid", bus.ic_ret_valid, 1);
        chk("t1_ret_last", bus.ic_ret_last, 1);
        chk("t1_dc_ret", bus.dc_ret_valid, 0);
        chk("t1_arvalid_idle", bus.arvalid, 0);
        cyc(1);
        r_off();

        // simultaneous requests, interleaved bursts
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_1000; bus.dc_rd_len = 1'b1;
        bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1C00_0000; bus.ic_rd_len = 1'b1;
        #1;
        chk("t2_dc_rdy", bus.dc_rd_rdy, 1);
        chk("t2_ic_rdy", bus.ic_rd_rdy, 0);
        exp_ar(ID_DC, 32'h0000_1000, 8'd3);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        #1;
        chk("t2_arid_dc", bus.arid, 1);
        chk("t2_ic_rdy_busy", bus.ic_rd_rdy, 0);
        cyc(1);
        chk("t2_ic_rdy_late", bus.ic_rd_rdy, 1);
        exp_ar(ID_IC, 32'h1C00_0000, 8'd3);
        cyc(1);
        bus.ic_rd_req = 1'b0;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            rbeat(ID_DC, 32'hD000_0000 + 32'(k), k == 3, 1'b1);
            cyc(1);
            rbeat(ID_IC, 32'hA000_0000 + 32'(k), k == 3, 1'b1);
            cyc(1);
        end
        r_off();
        chk("t2_ic_beats", ic_q.size(), 0);
        chk("t2_dc_beats", dc_q.size(), 0);

        // arready stall
        bus.arready = 1'b0;
        bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1C00_0200; bus.ic_rd_len = 1'b0;
        #1;
        chk("t3_ic_rdy", bus.ic_rd_rdy, 1);
        exp_ar(ID_IC, 32'h1C00_0200, 8'd0);
        cyc(1);
        bus.ic_rd_req = 1'b0;
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_3000; bus.dc_rd_len = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_arvalid", bus.arvalid, 1);
            chk("t3_araddr", bus.araddr, 32'h1C00_0200);
            chk("t3_dc_rdy", bus.dc_rd_rdy, 0);
            cyc(1);
        end
        bus.arready = 1'b1;
        #1;
        chk("t3_arvalid_hs", bus.arvalid, 1);
        chk("t3_dc_rdy_hs", bus.dc_rd_rdy, 0);
        cyc(1);
        chk("t3_dc_rdy_after", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_3000, 8'd0);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        cyc(1);
        rbeat(ID_IC, 32'h1111_1111, 1'b1, 1'b1);
        cyc(1);
        rbeat(ID_DC, 32'h2222_2222, 1'b1, 1'b1);
        cyc(1);
        r_off();

        // write-back hazard
        bus.wb_busy = 1'b1; bus.wb_addr = 32'h0000_2008;
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_2000; bus.dc_rd_len = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_dc_rdy_hz", bus.dc_rd_rdy, 0);
            cyc(1);
        end
        bus.wb_busy = 1'b0;
        #1;
        chk("t4_dc_rdy_clear", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_2000, 8'd3);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            rbeat(ID_DC, 32'hB000_0000 + 32'(k), k == 3, 1'b1);
            cyc(1);
        end
        r_off();
        bus.wb_busy = 1'b1;
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_2010; bus.dc_rd_len = 1'b0;
        #1;
        chk("t4_dc_rdy_other", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_2010, 8'd0);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h0000_200C; bus.ic_rd_len = 1'b0;
        cyc(1);
        chk("t4_ic_rdy_hz", bus.ic_rd_rdy, 0);
        cyc(1);
        chk("t4_ic_rdy_hz2", bus.ic_rd_rdy, 0);
        bus.wb_busy = 1'b0;
        #1;
        chk("t4_ic_rdy_clear", bus.ic_rd_rdy, 1);
        exp_ar(ID_IC, 32'h0000_200C, 8'd0);
        cyc(1);
        bus.ic_rd_req = 1'b0;
        cyc(1);
        rbeat(ID_DC, 32'h3333_3333, 1'b1, 1'b1);
        cyc(1);
        rbeat(ID_IC, 32'h4444_4444, 1'b1, 1'b1);
        cyc(1);
        r_off();

        // outstanding limit
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_4000; bus.dc_rd_len = 1'b1;
        #1;
        chk("t5_dc_rdy", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_4000, 8'd3);
        cyc(1);
        bus.dc_rd_addr = 32'h0000_5000; bus.dc_rd_len = 1'b0;
        #1;
        chk("t5_dc_rdy_busy", bus.dc_rd_rdy, 0);
        cyc(1);
        bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1C00_0300; bus.ic_rd_len = 1'b0;
        rbeat(ID_DC, 32'hC000_0000, 1'b0, 1'b1);
        #1;
        chk("t5_dc_rdy_os", bus.dc_rd_rdy, 0);
        chk("t5_ic_rdy", bus.ic_rd_rdy, 1);
        exp_ar(ID_IC, 32'h1C00_0300, 8'd0);
        cyc(1);
        bus.ic_rd_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            rbeat(ID_DC, 32'hC000_0000 + 32'(k), k == 3, 1'b1);
            #1;
            chk("t5_dc_rdy_inflight", bus.dc_rd_rdy, 0);
            cyc(1);
        end
        r_off();
        #1;
        chk("t5_dc_rdy_after_last", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_5000, 8'd0);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        cyc(1);
        rbeat(ID_IC, 32'h5555_5555, 1'b1, 1'b1);
        cyc(1);
        rbeat(ID_DC, 32'h6666_6666, 1'b1, 1'b1);
        cyc(1);
        r_off();

        // reset mid-burst
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_6000; bus.dc_rd_len = 1'b1;
        #1;
        chk("t6_dc_rdy", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_6000, 8'd3);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        cyc(1);
        rbeat(ID_DC, 32'hE000_0000, 1'b0, 1'b1);
        cyc(1);
        rbeat(ID_DC, 32'hE000_0001, 1'b0, 1'b1);
        cyc(1);
        r_off();
        resetn = 1'b0;
        cyc(1);
        chk("t6_rready_rst", bus.rready, 0);
        chk("t6_arvalid_rst", bus.arvalid, 0);
        rbeat(ID_DC, 32'hE000_0002, 1'b0, 1'b0);
        #1;
        chk("t6_ret_in_rst", bus.dc_ret_valid, 0);
        cyc(1);
        r_off();
        resetn = 1'b1;
        cyc(1);
        chk("t6_rready_back", bus.rready, 1);
        rbeat(ID_DC, 32'hE000_0003, 1'b1, 1'b0);
        #1;
        chk("t6_ret_dropped", bus.dc_ret_valid, 0);
        chk("t6_ret_last_dropped", bus.dc_ret_last, 0);
        cyc(1);
        r_off();
        bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h0000_7000; bus.dc_rd_len = 1'b0;
        #1;
        chk("t6_dc_rdy_post", bus.dc_rd_rdy, 1);
        exp_ar(ID_DC, 32'h0000_7000, 8'd0);
        cyc(1);
        bus.dc_rd_req = 1'b0;
        cyc(1);
        rbeat(ID_DC, 32'h7777_7777, 1'b1, 1'b1);
        cyc(1);
        r_off();
        cyc(2);

        chk("end_ar_q", ar_q.size(), 0);
        chk("end_ic_q", ic_q.size(), 0);
        chk("end_dc_q", dc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
